memory_access: RTL and testbench
================================

Name: memory_access

Overview:
Memory (M) stage of the 5-stage RISC-V pipeline, including the M/W pipeline register that feeds the writeback stage.
- Issues load/store requests to data memory over a valid/ready request channel and a valid response channel.
- Generates store byte-enables and replicated write data.
- Extracts and extends load data.
- Asserts StallM while a memory transaction is outstanding.
- Registers all W-stage operands (ResultSrcW, ALUResultW, ReadDataW, PCPlus4W, RdW, RegWriteW).

Parameters:
DATA_WIDTH, 32, datapath and address width (only 32 supported)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
RegWriteM  in  1  register write enable of instruction in M
ResultSrcM  in  2  00 ALU, 01 load data, 10 PC+4; 01 marks a load
MemWriteM  in  1  store
funct3M  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU
ALUResultM  in  DATA_WIDTH  effective address / ALU result
WriteDataM  in  DATA_WIDTH  store data (rs2)
RdM  in  5  destination register
PCPlus4M  in  DATA_WIDTH  PC+4
mem_req_valid  out  1  request valid
mem_req_ready  in  1  memory accepts request
mem_req_we  out  1  1 store, 0 load
mem_req_addr  out  DATA_WIDTH  {ALUResultM[31:2],2'b00}
mem_req_wdata  out  DATA_WIDTH  replicated store data
mem_req_be  out  4  byte enables (store only; 4'hF for loads)
mem_rsp_valid  in  1  load data valid
mem_rsp_rdata  in  DATA_WIDTH  aligned word read
StallM  out  1  hold M and all earlier stages
RegWriteW  out  1  registered; 0 during bubbles
ResultSrcW  out  2  registered
ALUResultW  out  DATA_WIDTH  registered
ReadDataW  out  DATA_WIDTH  registered, extended load data
PCPlus4W  out  DATA_WIDTH  registered
RdW  out  5  registered

Behaviour:
- MemOp = MemWriteM | (ResultSrcM==01). MemWriteM and load are never both set.
- FSM states:
  - IDLE: mem_req_valid = MemOp, combinationally.
    - Store with ready=1: completes this cycle, no stall.
    - Load with ready=1: go to RESP.
    - ready=0: go to REQ.
  - REQ: mem_req_valid=1 with identical fields.
    - ready=1: store completes (go IDLE); load goes to RESP.
  - RESP: mem_req_valid=0.
    - mem_rsp_valid=1: load completes, go IDLE.
- Request fields are stable while valid, because M inputs are held by StallM.
- Only one transaction is ever outstanding.
- Done = (store accepted this cycle) | (RESP & mem_rsp_valid).
- StallM = MemOp & ~Done. This is combinational. Non-memory instructions never stall.
- Store byte-enables, with a = ALUResultM[1:0]:
  - SB: be = 4'b0001<<a, wdata = WriteDataM[7:0] replicated x4.
  - SH: be = 4'b0011<<{a[1],0}, wdata = WriteDataM[15:0] replicated x2.
  - SW: be = 4'hF, wdata = WriteDataM.
  - a[0] is ignored for halfword and a[1:0] for word: misaligned accesses are silently aligned down.
- Load extraction uses ALUResultM[1:0] and funct3M, both held during the stall:
  - Select the byte or halfword lane from mem_rsp_rdata.
  - B/H: sign-extend; BU/HU: zero-extend; W: pass through.
- M/W register update, every clock edge:
  - StallM=0: all W outputs load their M counterparts; ReadDataW loads the extracted data (0 when not a load). Latency is 1 cycle.
  - StallM=1: RegWriteW<=0 (bubble). The other W outputs hold their values.
- Reset:
  - All W outputs are 0. FSM goes to IDLE and mem_req_valid=0 while rst=1.
  - Reset mid-transaction abandons the transaction.
  - mem_rsp_valid arriving in IDLE is ignored.

Test Plan:
- Back-to-back ALU ops (RdM=5, ALUResultM=0x1234) -> next cycle RegWriteW=1, RdW=5, ALUResultW=0x1234; StallM stays 0; mem_req_valid stays 0.
- SB, addr 0x1003, WriteDataM=0xAABBCCDD, ready=1 -> mem_req_addr=0x1000, be=1000, wdata=0xDDDDDDDD, StallM=0, no stall cycle.
- SH, addr 0x2002, ready low for 3 cycles -> StallM=1 for those 3 cycles with constant request fields, be=1100, W gets 3 bubbles (RegWriteW=0).
- LB at offset 1, rdata=0x0080FF00, response 2 cycles after accept -> ReadDataW=0xFFFFFFFF. Repeat as LBU -> 0x000000FF. As LHU at offset 2 -> 0x00000080.
- LW accepted, rst asserted before the response -> next cycle W outputs are 0 and the FSM is IDLE. A late mem_rsp_valid is ignored: StallM=0 and W is unchanged.
- JAL-type op (ResultSrcM=10, PCPlus4M=0x104) immediately after a stalled load -> load data is written first, then ResultSrcW=10, PCPlus4W=0x104 on the following cycle.

Source files
------------

// File: rtl/memory_access.sv
// M stage of the 5-stage RISC-V pipeline plus the M/W pipeline register.
// Ports: M-stage operands in; data memory req/rsp channels; StallM and W-stage operands out.
module memory_access #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RegWriteM,
  input  logic [1:0]            ResultSrcM,
  input  logic                  MemWriteM,
  input  logic [2:0]            funct3M,
  input  logic [DATA_WIDTH-1:0] ALUResultM,
  input  logic [DATA_WIDTH-1:0] WriteDataM,
  input  logic [4:0]            RdM,
  input  logic [DATA_WIDTH-1:0] PCPlus4M,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic                  mem_req_we,
  output logic [DATA_WIDTH-1:0] mem_req_addr,
  output logic [DATA_WIDTH-1:0] mem_req_wdata,
  output logic [3:0]            mem_req_be,
  input  logic                  mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] mem_rsp_rdata,
  output logic                  StallM,
  output logic                  RegWriteW,
  output logic [1:0]            ResultSrcW,
  output logic [DATA_WIDTH-1:0] ALUResultW,
  output logic [DATA_WIDTH-1:0] ReadDataW,
  output logic [DATA_WIDTH-1:0] PCPlus4W,
  output logic [4:0]            RdW
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_RESP
  } state_e;

  typedef struct packed {
    logic                  rw;
    logic [1:0]            rs;
    logic [DATA_WIDTH-1:0] alu;
    logic [DATA_WIDTH-1:0] rdat;
    logic [DATA_WIDTH-1:0] pc4;
    logic [4:0]            rd;
  } w_t;

  state_e state_q, state_d;
  w_t     w_q, w_d;

  logic                  is_load;
  logic                  mem_op;
  logic                  store_acc;
  logic                  rsp_done;
  logic [1:0]            a;
  logic [7:0]            ld_byte;
  logic [15:0]           ld_half;
  logic [DATA_WIDTH-1:0] ld_data;

  assign is_load = (ResultSrcM == 2'b01);
  assign mem_op  = MemWriteM | is_load;
  assign a       = ALUResultM[1:0];

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (mem_op) begin
          if (!mem_req_ready) state_d = S_REQ;
          else if (is_load)   state_d = S_RESP;
        end
      end
      S_REQ: begin
        if (mem_req_ready)
          state_d = is_load ? S_RESP : S_IDLE;
      end
      S_RESP: begin
        if (mem_rsp_valid) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mem_req_valid = 1'b0;
    case (state_q)
      S_IDLE:  mem_req_valid = mem_op & ~rst;
      S_REQ:   mem_req_valid = ~rst;
      default: mem_req_valid = 1'b0;
    endcase
  end

  // A store is finished the cycle it is accepted; a load only on its response.
  assign store_acc = MemWriteM & mem_req_valid & mem_req_ready;
  assign rsp_done  = (state_q == S_RESP) & mem_rsp_valid;
  assign StallM    = mem_op & ~(store_acc | rsp_done);

  assign mem_req_we   = MemWriteM;
  assign mem_req_addr = {ALUResultM[DATA_WIDTH-1:2], 2'b00};

  // Misaligned halfword/word stores are aligned down by dropping low bits.
  always_comb begin
    mem_req_be    = 4'hF;
    mem_req_wdata = WriteDataM;
    if (MemWriteM) begin
      case (funct3M[1:0])
        2'b00: begin
          mem_req_be    = 4'b0001 << a;
          mem_req_wdata = {4{WriteDataM[7:0]}};
        end
        2'b01: begin
          mem_req_be    = 4'b0011 << {a[1], 1'b0};
          mem_req_wdata = {2{WriteDataM[15:0]}};
        end
        default: begin
          mem_req_be    = 4'hF;
          mem_req_wdata = WriteDataM;
        end
      endcase
    end
  end

  always_comb begin
    case (a)
      2'd0:    ld_byte = mem_rsp_rdata[7:0];
      2'd1:    ld_byte = mem_rsp_rdata[15:8];
      2'd2:    ld_byte = mem_rsp_rdata[23:16];
      default: ld_byte = mem_rsp_rdata[31:24];
    endcase
    ld_half = a[1] ? mem_rsp_rdata[31:16] : mem_rsp_rdata[15:0];
    case (funct3M)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_data = {24'd0, ld_byte};
      3'b101:  ld_data = {16'd0, ld_half};
      default: ld_data = mem_rsp_rdata;
    endcase
  end

  // A stall inserts a bubble into W; the other W fields simply hold.
  always_comb begin
    w_d = w_q;
    if (StallM) begin
      w_d.rw = 1'b0;
    end else begin
      w_d.rw   = RegWriteM;
      w_d.rs   = ResultSrcM;
      w_d.alu  = ALUResultM;
      w_d.rdat = is_load ? ld_data : '0;
      w_d.pc4  = PCPlus4M;
      w_d.rd   = RdM;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) w_q <= '0;
    else     w_q <= w_d;
  end

  assign RegWriteW  = w_q.rw;
  assign ResultSrcW = w_q.rs;
  assign ALUResultW = w_q.alu;
  assign ReadDataW  = w_q.rdat;
  assign PCPlus4W   = w_q.pc4;
  assign RdW        = w_q.rd;

endmodule

// File: tb/tb_memory_access.sv
// Testbench for memory_access: scenario tasks with a scoreboard of
// expected W-stage bundles, compared when each instruction leaves M.
module tb_memory_access;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWriteM;
  logic [1:0]  ResultSrcM;
  logic        MemWriteM;
  logic [2:0]  funct3M;
  logic [31:0] ALUResultM;
  logic [31:0] WriteDataM;
  logic [4:0]  RdM;
  logic [31:0] PCPlus4M;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_we;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_wdata;
  logic [3:0]  mem_req_be;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_rdata;
  logic        StallM;
  logic        RegWriteW;
  logic [1:0]  ResultSrcW;
  logic [31:0] ALUResultW;
  logic [31:0] ReadDataW;
  logic [31:0] PCPlus4W;
  logic [4:0]  RdW;

  typedef struct packed {
    logic        rw;
    logic [1:0]  rs;
    logic [31:0] alu;
    logic [31:0] rdat;
    logic [31:0] pc4;
    logic [4:0]  rd;
  } w_t;

  w_t   sb[$];
  w_t   w_obs;
  w_t   e;
  int   passed = 0;
  int   total  = 0;

  assign w_obs = {RegWriteW, ResultSrcW, ALUResultW,
                  ReadDataW, PCPlus4W, RdW};

  memory_access #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM),
    .MemWriteM(MemWriteM), .funct3M(funct3M),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .RdM(RdM), .PCPlus4M(PCPlus4M),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata), .mem_req_be(mem_req_be),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata),
    .StallM(StallM),
    .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW),
    .ALUResultW(ALUResultW), .ReadDataW(ReadDataW),
    .PCPlus4W(PCPlus4W), .RdW(RdW)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, time=%0t required<200000", $time);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_m(input logic rw, input logic [1:0] rs,
                       input logic mw, input logic [2:0] f3,
                       input logic [31:0] alu, input logic [31:0] wd,
                       input logic [4:0] rd, input logic [31:0] pc4);
    RegWriteM  = rw;
    ResultSrcM = rs;
    MemWriteM  = mw;
    funct3M    = f3;
    ALUResultM = alu;
    WriteDataM = wd;
    RdM        = rd;
    PCPlus4M   = pc4;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    mem_req_ready = 1'b1;
    mem_rsp_valid = 1'b0;
    mem_rsp_rdata = 32'h0;
    set_m(1'b1, 2'b00, 1'b1, 3'b010, 32'h10, 32'h55, 5'd3, 32'h8);
    step();
    step();
    total++;
    if (w_obs !== '0)
      $display("FAIL reset_w: got %h want 0", w_obs);
    else passed++;
    total++;
    if (mem_req_valid !== 1'b0)
      $display("FAIL reset_valid: got %b want 0", mem_req_valid);
    else passed++;
    rst = 1'b0;
    set_m(1'b0, 2'b00, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0, 32'h0);
    #1;
    total++;
    if (StallM !== 1'b0)
      $display("FAIL reset_stall: got %b want 0", StallM);
    else passed++;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) begin
      set_m(1'b1, 2'b00, 1'b0, 3'b000, 32'h1234 + i, 32'hFFFF,
            5'(5 + i), 32'h100 + 4 * i);
      sb.push_back('{1'b1, 2'b00, 32'h1234 + i, 32'h0,
                     32'h100 + 4 * i, 5'(5 + i)});
      #1;
      total++;
      if (StallM !== 1'b0 || mem_req_valid !== 1'b0)
        $display("FAIL b2b_ctl[%0d]: stall=%b valid=%b want 0 0",
                 i, StallM, mem_req_valid);
      else passed++;
      step();
      e = sb.pop_front();
      total++;
      if (w_obs !== e)
        $display("FAIL b2b_w[%0d]: got %h want %h", i, w_obs, e);
      else passed++;
    end
  endtask

  task automatic test_store_byte();
    mem_req_ready = 1'b1;
    set_m(1'b0, 2'b00, 1'b1, 3'b000, 32'h1003, 32'hAABBCCDD,
          5'd0, 32'h200);
    sb.push_back('{1'b0, 2'b00, 32'h1003, 32'h0, 32'h200, 5'd0});
    #1;
    total++;
    if ({mem_req_valid, mem_req_we, mem_req_addr, mem_req_be,
         mem_req_wdata, StallM} !==
        {1'b1, 1'b1, 32'h1000, 4'b1000, 32'hDDDDDDDD, 1'b0})
      $display("FAIL sb_req: v=%b we=%b a=%h be=%b wd=%h st=%b want 1 1 1000 1000 dddddddd 0",
               mem_req_valid, mem_req_we, mem_req_addr,
               mem_req_be, mem_req_wdata, StallM);
    else passed++;
    step();
    e = sb.pop_front();
    total++;
    if (w_obs !== e)
      $display("FAIL sb_w: got %h want %h", w_obs, e);
    else passed++;
  endtask

  task automatic test_store_half_stall();
    set_m(1'b1, 2'b00, 1'b0, 3'b000, 32'h77, 32'h0, 5'd7, 32'h204);
    sb.push_back('{1'b1, 2'b00, 32'h77, 32'h0, 32'h204, 5'd7});
    step();
    e = sb.pop_front();
    total++;
    if (w_obs !== e)
      $display("FAIL sh_pre_w: got %h want %h", w_obs, e);
    else passed++;
    mem_req_ready = 1'b0;
    set_m(1'b0, 2'b00, 1'b1, 3'b001, 32'h2002, 32'h11223344,
          5'd0, 32'h208);
    sb.push_back('{1'b0, 2'b00, 32'h2002, 32'h0, 32'h208, 5'd0});
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if ({StallM, mem_req_valid, mem_req_addr, mem_req_be,
           mem_req_wdata} !==
          {1'b1, 1'b1, 32'h2000, 4'b1100, 32'h33443344})
        $display("FAIL sh_stall[%0d]: st=%b v=%b a=%h be=%b wd=%h want 1 1 2000 1100 33443344",
                 i, StallM, mem_req_valid, mem_req_addr,
                 mem_req_be, mem_req_wdata);
      else passed++;
      step();
      total++;
      if (RegWriteW !== 1'b0 || RdW !== 5'd7)
        $display("FAIL sh_bubble[%0d]: rw=%b rd=%0d want 0 7",
                 i, RegWriteW, RdW);
      else passed++;
    end
    mem_req_ready = 1'b1;
    #1;
    total++;
    if (StallM !== 1'b0 || mem_req_valid !== 1'b1)
      $display("FAIL sh_accept: st=%b v=%b want 0 1",
               StallM, mem_req_valid);
    else passed++;
    step();
    e = sb.pop_front();
    total++;
    if (w_obs !== e)
      $display("FAIL sh_w: got %h want %h", w_obs, e);
    else passed++;
  endtask

  task automatic test_load(input string nm, input logic [2:0] f3,
                           input logic [31:0] addr,
                           input logic [31:0] rdata,
                           input logic [31:0] exp);
    mem_req_ready = 1'b1;
    mem_rsp_valid = 1'b0;
    set_m(1'b1, 2'b01, 1'b0, f3, addr, 32'h0, 5'd10, 32'h300);
    sb.push_back('{1'b1, 2'b01, addr, exp, 32'h300, 5'd10});
    #1;
    total++;
    if ({mem_req_valid, mem_req_we, mem_req_be, StallM} !==
        {1'b1, 1'b0, 4'hF, 1'b1})
      $display("FAIL %s_req: v=%b we=%b be=%b st=%b want 1 0 1111 1",
               nm, mem_req_valid, mem_req_we, mem_req_be, StallM);
    else passed++;
    step();
    mem_req_ready = 1'b0;
    #1;
    total++;
    if (mem_req_valid !== 1'b0 || StallM !== 1'b1)
      $display("FAIL %s_wait: v=%b st=%b want 0 1",
               nm, mem_req_valid, StallM);
    else passed++;
    step();
    mem_rsp_valid = 1'b1;
    mem_rsp_rdata = rdata;
    #1;
    total++;
    if (StallM !== 1'b0 || RegWriteW !== 1'b0)
      $display("FAIL %s_rsp: st=%b rw=%b want 0 0",
               nm, StallM, RegWriteW);
    else passed++;
    step();
    mem_rsp_valid = 1'b0;
    e = sb.pop_front();
    total++;
    if (w_obs !== e)
      $display("FAIL %s_w: got %h want %h", nm, w_obs, e);
    else passed++;
  endtask

  task automatic test_reset_mid_load();
    mem_req_ready = 1'b1;
    set_m(1'b1, 2'b01, 1'b0, 3'b010, 32'h3000, 32'h0, 5'd12, 32'h400);
    step();
    mem_req_ready = 1'b0;
    rst = 1'b1;
    step();
    total++;
    if (w_obs !== '0 || mem_req_valid !== 1'b0)
      $display("FAIL rstmid_w: w=%h v=%b want 0 0", w_obs, mem_req_valid);
    else passed++;
    rst = 1'b0;
    set_m(1'b0, 2'b00, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0, 32'h0);
    mem_rsp_valid = 1'b1;
    mem_rsp_rdata = 32'hDEADBEEF;
    sb.push_back('0);
    #1;
    total++;
    if (StallM !== 1'b0 || mem_req_valid !== 1'b0)
      $display("FAIL rstmid_late: st=%b v=%b want 0 0",
               StallM, mem_req_valid);
    else passed++;
    step();
    mem_rsp_valid = 1'b0;
    e = sb.pop_front();
    total++;
    if (w_obs !== e)
      $display("FAIL rstmid_hold: got %h want %h", w_obs, e);
    else passed++;
    mem_req_ready = 1'b1;
    set_m(1'b0, 2'b00, 1'b1, 3'b010, 32'h3004, 32'h12345678,
          5'd0, 32'h404);
    sb.push_back('{1'b0, 2'b00, 32'h3004, 32'h0, 32'h404, 5'd0});
    #1;
    total++;
    if ({mem_req_valid, StallM, mem_req_be, mem_req_wdata} !==
        {1'b1, 1'b0, 4'hF, 32'h12345678})
      $display("FAIL rstmid_idle: v=%b st=%b be=%b wd=%h want 1 0 1111 12345678",
               mem_req_valid, StallM, mem_req_be, mem_req_wdata);
    else passed++;
    step();
    e = sb.pop_front();
    total++;
    if (w_obs !== e)
      $display("FAIL rstmid_sw_w: got %h want %h", w_obs, e);
    else passed++;
  endtask

  task automatic test_jal_after_load();
    mem_req_ready = 1'b0;
    set_m(1'b1, 2'b01, 1'b0, 3'b010, 32'h4000, 32'h0, 5'd9, 32'h100);
    sb.push_back('{1'b1, 2'b01, 32'h4000, 32'hCAFEBABE, 32'h100, 5'd9});
    step();
    mem_req_ready = 1'b1;
    #1;
    total++;
    if (StallM !== 1'b1 || mem_req_valid !== 1'b1)
      $display("FAIL jal_ldreq: st=%b v=%b want 1 1",
               StallM, mem_req_valid);
    else passed++;
    step();
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rsp_rdata = 32'hCAFEBABE;
    step();
    mem_rsp_valid = 1'b0;
    e = sb.pop_front();
    total++;
    if (w_obs !== e)
      $display("FAIL jal_ld_w: got %h want %h", w_obs, e);
    else passed++;
    set_m(1'b1, 2'b10, 1'b0, 3'b000, 32'h200, 32'h0, 5'd1, 32'h104);
    sb.push_back('{1'b1, 2'b10, 32'h200, 32'h0, 32'h104, 5'd1});
    #1;
    total++;
    if (StallM !== 1'b0)
      $display("FAIL jal_stall: got %b want 0", StallM);
    else passed++;
    step();
    e = sb.pop_front();
    total++;
    if (w_obs !== e)
      $display("FAIL jal_w: got %h want %h", w_obs, e);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_store_byte();
    test_store_half_stall();
    test_load("lb",  3'b000, 32'h5001, 32'h0080FF00, 32'hFFFFFFFF);
    test_load("lbu", 3'b100, 32'h5001, 32'h0080FF00, 32'h000000FF);
    test_load("lhu", 3'b101, 32'h5002, 32'h0080FF00, 32'h00000080);
    test_load("lh",  3'b001, 32'h5002, 32'h8001FF00, 32'hFFFF8001);
    test_reset_mid_load();
    test_jal_after_load();
    total++;
    if (sb.size() != 0)
      $display("FAIL sb_drain: got %0d left want 0", sb.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
